// File: rtl/hps_reset_req_ctrl.sv
// HPS reset request sequencer: arbitrates a debounced key press against fabric requests and
// drives one active-low f2h reset request pulse, then tracks the h2f_reset_n handshake.
//   state    | meaning
//   IDLE     | arbitrate pending key press and fabric requests
//   ASSERT   | selected f2h_*_reset_req_n held low for PULSE_CYCLES
//   WAIT_LO  | cold/warm: wait for h2f_reset_n to go low
//   WAIT_HI  | cold/warm: wait for h2f_reset_n to return high
//   COOLDOWN | enforced idle gap before the next request
module hps_reset_req_ctrl #(
    parameter int PULSE_CYCLES    = 16,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 5000000,
    parameter int COOLDOWN_CYCLES = 1024,
    parameter int CNT_W           = 23
) (
    input  logic       clk_clk_i,
    input  logic       reset_reset_n_i,
    input  logic       key_n_i,
    input  logic       req_valid_i,
    input  logic [1:0] req_type_i,
    output logic       req_ready_o,
    input  logic       h2f_reset_n_i,
    output logic       f2h_cold_reset_req_n_o,
    output logic       f2h_warm_reset_req_n_o,
    output logic       f2h_debug_reset_req_n_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [1:0] last_type_o,
    output logic       timeout_err_o,
    output logic       bad_req_o
);

    typedef enum logic [2:0] {S_IDLE, S_ASSERT, S_WAIT_LO, S_WAIT_HI, S_COOLDOWN} state_t;

    localparam logic [1:0] T_DEBUG = 2'd0;
    localparam logic [1:0] T_WARM  = 2'd1;
    localparam logic [1:0] T_COLD  = 2'd2;
    localparam logic [1:0] T_BAD   = 2'd3;

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LD    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CD_LD    = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_LD    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]       type_q, type_d;
    logic             key_s1_q, key_s2_q, key_d1_q;
    logic             h2f_s1_q, h2f_s2_q;
    logic             armed_q, armed_d;
    logic             key_pend_q, key_pend_d;
    logic             to_err_q, to_err_d;
    logic             bad_q, bad_d;
    logic             run_q, done_q;
    logic             cold_n_q, warm_n_q, dbg_n_q;
    logic             press, take_key, accept;

    // A press only counts after the key has also been seen stable high (armed).
    always_comb begin
        db_cnt_d = db_cnt_q;
        armed_d  = armed_q;
        press    = 1'b0;
        if (key_s2_q != key_d1_q) begin
            db_cnt_d = DB_LD;
        end else if (db_cnt_q != '0) begin
            db_cnt_d = db_cnt_q - ONE;
            if (db_cnt_q == ONE) begin
                if (!key_s2_q) begin
                    press   = armed_q;
                    armed_d = 1'b0;
                end else begin
                    armed_d = 1'b1;
                end
            end
        end
    end

    assign req_ready_o = run_q && (state_q == S_IDLE) && !(key_pend_q && (req_type_i != T_COLD));
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        type_d   = type_q;
        to_err_d = to_err_q;
        bad_d    = bad_q;
        take_key = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && (req_type_i == T_COLD)) begin
                    state_d = S_ASSERT;
                    cnt_d   = PULSE_LD;
                    type_d  = T_COLD;
                end else if (key_pend_q) begin
                    state_d  = S_ASSERT;
                    cnt_d    = PULSE_LD;
                    type_d   = T_WARM;
                    take_key = 1'b1;
                end else if (accept) begin
                    if (req_type_i == T_BAD) begin
                        bad_d = 1'b1;
                    end else begin
                        state_d = S_ASSERT;
                        cnt_d   = PULSE_LD;
                        type_d  = req_type_i;
                    end
                end
            end
            S_ASSERT: begin
                if (cnt_q == '0) begin
                    state_d = (type_q == T_DEBUG) ? S_COOLDOWN : S_WAIT_LO;
                    cnt_d   = (type_q == T_DEBUG) ? CD_LD : TO_LD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_WAIT_LO: begin
                if (!h2f_s2_q) begin
                    state_d = S_WAIT_HI;
                    cnt_d   = TO_LD;
                end else if (cnt_q == '0) begin
                    state_d  = S_COOLDOWN;
                    cnt_d    = CD_LD;
                    to_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_WAIT_HI: begin
                if (h2f_s2_q) begin
                    state_d = S_COOLDOWN;
                    cnt_d   = CD_LD;
                end else if (cnt_q == '0) begin
                    state_d  = S_COOLDOWN;
                    cnt_d    = CD_LD;
                    to_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_COOLDOWN: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - ONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign key_pend_d = (key_pend_q && !take_key) || press;

    // Request outputs are registered from the next state so the HPS never sees decode glitches.
    always_ff @(posedge clk_clk_i) begin
        if (!reset_reset_n_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            type_q     <= T_DEBUG;
            key_s1_q   <= 1'b1;
            key_s2_q   <= 1'b1;
            key_d1_q   <= 1'b1;
            h2f_s1_q   <= 1'b1;
            h2f_s2_q   <= 1'b1;
            db_cnt_q   <= DB_LD;
            armed_q    <= 1'b0;
            key_pend_q <= 1'b0;
            to_err_q   <= 1'b0;
            bad_q      <= 1'b0;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
            cold_n_q   <= 1'b1;
            warm_n_q   <= 1'b1;
            dbg_n_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            type_q     <= type_d;
            key_s1_q   <= key_n_i;
            key_s2_q   <= key_s1_q;
            key_d1_q   <= key_s2_q;
            h2f_s1_q   <= h2f_reset_n_i;
            h2f_s2_q   <= h2f_s1_q;
            db_cnt_q   <= db_cnt_d;
            armed_q    <= armed_d;
            key_pend_q <= key_pend_d;
            to_err_q   <= to_err_d;
            bad_q      <= bad_d;
            run_q      <= 1'b1;
            done_q     <= (state_d == S_COOLDOWN) && (state_q != S_COOLDOWN);
            cold_n_q   <= !((state_d == S_ASSERT) && (type_d == T_COLD));
            warm_n_q   <= !((state_d == S_ASSERT) && (type_d == T_WARM));
            dbg_n_q    <= !((state_d == S_ASSERT) && (type_d == T_DEBUG));
        end
    end

    assign f2h_cold_reset_req_n_o  = cold_n_q;
    assign f2h_warm_reset_req_n_o  = warm_n_q;
    assign f2h_debug_reset_req_n_o = dbg_n_q;
    assign busy_o                  = (state_q != S_IDLE);
    assign done_o                  = done_q;
    assign last_type_o             = type_q;
    assign timeout_err_o           = to_err_q;
    assign bad_req_o               = bad_q;

endmodule
